// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: widths and FSM states.
package adder_arbiter_pkg;

    localparam int W    = 6;
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// The team's plain W-bit adder: sum and carry-out, no carry-in.
module adder #(
    parameter int W = 6
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic         cout
);

    // Zero-extend both operands so the top bit of the result is the carry.
    assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a single shared adder. Each accepted request
// is computed in CALC and held in RESP until the consumer takes it.
module adder_arbiter #(
    parameter int W    = adder_arbiter_pkg::W,
    parameter int NREQ = adder_arbiter_pkg::NREQ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [W-1:0]    req_x0,
    input  logic [W-1:0]    req_y0,
    input  logic [W-1:0]    req_x1,
    input  logic [W-1:0]    req_y1,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_cout,
    output logic            busy
);

    import adder_arbiter_pkg::*;

    state_t         state;
    state_t         next_state;
    logic           last_grant;
    logic           grant_id;
    logic           grant_any;
    logic [W-1:0]   op_x;
    logic [W-1:0]   op_y;
    logic           op_id;
    logic [W-1:0]   add_s;
    logic           add_cout;

    adder #(.W(W)) u_adder (
        .x    (op_x),
        .y    (op_y),
        .s    (add_s),
        .cout (add_cout)
    );

    // Pick the winner: alternate away from the last grant when both compete.
    always_comb begin
        grant_id  = 1'b0;
        grant_any = req_valid[0] | req_valid[1];
        if (req_valid[0] && req_valid[1]) begin
            grant_id = ~last_grant;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    // Only IDLE accepts work, and never while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Next-state logic; stray encodings fall back to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_any) next_state = CALC;
            CALC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Capture the winner's operands on transfer, register the sum in CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_x       <= '0;
            op_y       <= '0;
            op_id      <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            if (state == IDLE && grant_any) begin
                op_x       <= grant_id ? req_x1 : req_x0;
                op_y       <= grant_id ? req_y1 : req_y0;
                op_id      <= grant_id;
                last_grant <= grant_id;
            end
            if (state == CALC) begin
                rsp_sum  <= add_s;
                rsp_cout <= add_cout;
                rsp_id   <= op_id;
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios with literal
// expectations, then a long randomized run against a transaction-level model.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_x0, req_y0, req_x1, req_y1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [5:0] rsp_sum;
    logic       rsp_cout;
    logic       busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Transaction-level model: age of the in-flight request (-1 none,
    // 0 just accepted, 1 result presented), plus arbitration memory.
    int m_age;
    int m_last;
    int m_zero;
    int m_sum, m_cout, m_id;
    int p_sum, p_cout, p_id;
    int accepts, responses, discarded, cycles;

    adder_arbiter #(.W(6), .NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x0    (req_x0),
        .req_y0    (req_y0),
        .req_x1    (req_x1),
        .req_y1    (req_y1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        rst_n        = ($urandom_range(0, 299) != 0);
        req_valid[0] = ($urandom_range(0, 9) < 7);
        req_valid[1] = ($urandom_range(0, 9) < 7);
        req_x0       = 6'($urandom);
        req_y0       = 6'($urandom);
        req_x1       = 6'($urandom);
        req_y1       = 6'($urandom);
        rsp_ready    = ($urandom_range(0, 3) != 0);
    endtask

    task automatic checkOutput();
        int grant;
        int exp_ready;
        grant     = 0;
        exp_ready = 0;
        if (rst_n && m_age < 0 && req_valid != 2'b00) begin
            if (req_valid == 2'b11) grant = (m_last == 1) ? 0 : 1;
            else                    grant = req_valid[1] ? 1 : 0;
            exp_ready = (grant == 1) ? 2 : 1;
        end
        checkValue("rnd_req_ready", int'(req_ready), exp_ready);
        checkValue("rnd_rsp_valid", int'(rsp_valid), (m_age >= 1) ? 1 : 0);
        checkValue("rnd_busy", int'(busy), (m_age >= 0) ? 1 : 0);
        if (m_age >= 1 || m_zero == 1) begin
            checkValue("rnd_rsp_sum", int'(rsp_sum), m_sum);
            checkValue("rnd_rsp_cout", int'(rsp_cout), m_cout);
            checkValue("rnd_rsp_id", int'(rsp_id), m_id);
        end
    endtask

    task automatic modelReset();
        m_age  = -1;
        m_last = 1;
        m_zero = 1;
        m_sum  = 0;
        m_cout = 0;
        m_id   = 0;
    endtask

    task automatic advanceModel();
        int total;
        if (!rst_n) begin
            if (m_age >= 0) discarded++;
            modelReset();
        end else if (m_age < 0) begin
            if (req_valid != 2'b00) begin
                if (req_valid == 2'b11) p_id = (m_last == 1) ? 0 : 1;
                else                    p_id = req_valid[1] ? 1 : 0;
                total  = (p_id == 1) ? int'(req_x1) + int'(req_y1)
                                     : int'(req_x0) + int'(req_y0);
                p_sum  = total % 64;
                p_cout = (total >= 64) ? 1 : 0;
                m_last = p_id;
                m_age  = 0;
                accepts++;
            end
        end else if (m_age == 0) begin
            m_age  = 1;
            m_zero = 0;
            m_sum  = p_sum;
            m_cout = p_cout;
            m_id   = p_id;
        end else if (rsp_ready) begin
            m_age = -1;
            responses++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        req_x0 = 6'd0; req_y0 = 6'd0; req_x1 = 6'd0; req_y1 = 6'd0;
        @(negedge clk);
        cyc();

        // Reset state, with requests pending
        checkValue("rst_req_ready", int'(req_ready), 0);
        checkValue("rst_rsp_valid", int'(rsp_valid), 0);
        checkValue("rst_busy", int'(busy), 0);
        checkValue("rst_rsp_sum", int'(rsp_sum), 0);
        checkValue("rst_rsp_cout", int'(rsp_cout), 0);
        checkValue("rst_rsp_id", int'(rsp_id), 0);

        // 63 + 1 from requester 0: wraps to 0 with carry
        rst_n = 1'b1; req_valid = 2'b01; req_x0 = 6'd63; req_y0 = 6'd1; rsp_ready = 1'b1;
        #1 checkValue("t1_ready", int'(req_ready), 1);
        cyc();
        req_valid = 2'b00;
        #1 checkValue("t1_calc_busy", int'(busy), 1);
        checkValue("t1_calc_valid", int'(rsp_valid), 0);
        cyc();
        checkValue("t1_valid", int'(rsp_valid), 1);
        checkValue("t1_id", int'(rsp_id), 0);
        checkValue("t1_sum", int'(rsp_sum), 0);
        checkValue("t1_cout", int'(rsp_cout), 1);
        checkValue("t1_resp_ready", int'(req_ready), 0);
        cyc();
        checkValue("t1_idle_busy", int'(busy), 0);
        checkValue("t1_idle_valid", int'(rsp_valid), 0);

        // Both requesters always valid: grants alternate starting with 0
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        req_x0 = 6'd5; req_y0 = 6'd7; req_x1 = 6'd20; req_y1 = 6'd30;
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 checkValue("t2_ready", int'(req_ready), (k % 2 == 1) ? 2 : 1);
            cyc();
            cyc();
            checkValue("t2_valid", int'(rsp_valid), 1);
            checkValue("t2_id", int'(rsp_id), k % 2);
            checkValue("t2_sum", int'(rsp_sum), (k % 2 == 1) ? 50 : 12);
            checkValue("t2_cout", int'(rsp_cout), 0);
            cyc();
        end

        // Requester 1, 40 + 40, consumer stalls for 5 cycles
        req_valid = 2'b10; req_x1 = 6'd40; req_y1 = 6'd40; rsp_ready = 1'b0;
        #1 checkValue("t3_ready", int'(req_ready), 2);
        cyc();
        req_valid = 2'b11;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1 checkValue("t3_hold_valid", int'(rsp_valid), 1);
            checkValue("t3_hold_sum", int'(rsp_sum), 16);
            checkValue("t3_hold_cout", int'(rsp_cout), 1);
            checkValue("t3_hold_id", int'(rsp_id), 1);
            checkValue("t3_hold_ready", int'(req_ready), 0);
            cyc();
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        cyc();

        // Reset while a result is presented discards it
        req_valid = 2'b01; req_x0 = 6'd1; req_y0 = 6'd2; rsp_ready = 1'b0;
        cyc();
        req_valid = 2'b00;
        cyc();
        checkValue("t4_pre_valid", int'(rsp_valid), 1);
        checkValue("t4_pre_sum", int'(rsp_sum), 3);
        rst_n = 1'b0;
        cyc();
        req_valid = 2'b11;
        #1 checkValue("t4_rst_valid", int'(rsp_valid), 0);
        checkValue("t4_rst_busy", int'(busy), 0);
        checkValue("t4_rst_sum", int'(rsp_sum), 0);
        checkValue("t4_rst_cout", int'(rsp_cout), 0);
        checkValue("t4_rst_id", int'(rsp_id), 0);
        checkValue("t4_rst_ready", int'(req_ready), 0);
        rst_n = 1'b1;
        #1 checkValue("t4_first_grant", int'(req_ready), 1);
        cyc();
        req_valid = 2'b00;
        cyc();
        checkValue("t4_post_id", int'(rsp_id), 0);
        checkValue("t4_post_sum", int'(rsp_sum), 3);
        rsp_ready = 1'b1;
        cyc();

        // Operands change right after transfer: result must not follow
        req_valid = 2'b01; req_x0 = 6'd0; req_y0 = 6'd0;
        #1 checkValue("t5_ready", int'(req_ready), 1);
        cyc();
        req_x0 = 6'd63; req_y0 = 6'd63; req_valid = 2'b00;
        cyc();
        checkValue("t5_valid", int'(rsp_valid), 1);
        checkValue("t5_sum", int'(rsp_sum), 0);
        checkValue("t5_cout", int'(rsp_cout), 0);
        cyc();

        // Randomized run against the transaction model
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        cyc();
        modelReset();
        accepts = 0; responses = 0; discarded = 0; cycles = 0;
        while (responses < 10000 && cycles < 80000) begin
            applyStimulus();
            #1;
            checkOutput();
            advanceModel();
            cyc();
            cycles++;
        end
        if (responses < 10000) begin
            checkValue("rnd_cycle_budget", responses, 10000);
        end
        checkValue("rnd_accept_balance", accepts,
                   responses + discarded + ((m_age >= 0) ? 1 : 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
